// File: rtl/note_stream_pkg.sv
`default_nettype none
// ============================================================================
// note_stream_pkg : state codes, ASCII constants and note-to-ASCII helper
// Optional feature macro: NOTE_STREAM_FRAMING_EN
// Revision: 1.0
// ============================================================================
package note_stream_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_CHECK = 3'd1;
  localparam state_t ST_WAIT  = 3'd2;
  localparam state_t ST_SEND0 = 3'd3;
  localparam state_t ST_SEND1 = 3'd4;
  localparam state_t ST_DONE  = 3'd5;
`ifdef NOTE_STREAM_FRAMING_EN
  localparam state_t ST_SEND2 = 3'd6;
  localparam state_t ST_TERM  = 3'd7;
`endif

  localparam logic [7:0] ASCII_TILE_BASE = 8'h61;  // 'a'
  localparam logic [7:0] ASCII_DUR_BASE  = 8'h30;  // '0'
  localparam logic [7:0] ASCII_ERR       = 8'h58;  // 'X'
  localparam logic [7:0] ASCII_NL        = 8'h0A;
  localparam logic [7:0] ASCII_TERM      = 8'h5A;  // 'Z'

  typedef struct packed {
    logic [7:0] b0;
    logic [7:0] b1;
    logic       err;
  } note_ascii_t;

  function automatic note_ascii_t note_to_ascii(input logic [7:0] tile,
                                                input logic [7:0] dur);
    note_ascii_t r;
    r.b0  = ASCII_TILE_BASE + tile;
    r.err = (dur == 8'd0);
    r.b1  = r.err ? ASCII_ERR : (ASCII_DUR_BASE + dur);
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/note_stream_tx_fmt.sv
`default_nettype none
// ============================================================================
// note_fmt : registered formatter, note word {tile, dur} -> two ASCII bytes
// Revision: 1.0
// ============================================================================
module note_fmt
  import note_stream_pkg::*;
#(
  parameter int TILE_W = 4,
  parameter int DUR_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [TILE_W+DUR_W-1:0] note,
  output logic [7:0]              buf0,
  output logic [7:0]              buf1,
  output logic                    err
);

  note_ascii_t fmt_d;
  note_ascii_t fmt_q;
  logic [7:0]  tile_ext;
  logic [7:0]  dur_ext;

  always_comb begin
    tile_ext = 8'(note[TILE_W+DUR_W-1:DUR_W]);
    dur_ext  = 8'(note[DUR_W-1:0]);
    fmt_d    = load ? note_to_ascii(tile_ext, dur_ext) : fmt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fmt_q <= '0;
    else      fmt_q <= fmt_d;
  end

  assign buf0 = fmt_q.b0;
  assign buf1 = fmt_q.b1;
  assign err  = fmt_q.err;

endmodule
`default_nettype wire

// File: rtl/note_stream_tx.sv
`default_nettype none
// ============================================================================
// note_stream_tx : streams a selected song from note memory as ASCII bytes
// over a valid/ready byte link. rst is asynchronous, active-low.
// Optional feature macro: NOTE_STREAM_FRAMING_EN (newline per note, 'Z' end)
// Revision: 1.0
// ============================================================================
module note_stream_tx
  import note_stream_pkg::*;
#(
  parameter int  NUM_SONGS = 4,
  parameter int  MAX_NOTES = 64,
  parameter int  TILE_W    = 4,
  parameter int  DUR_W     = 3,
  localparam int SONG_W    = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1,
  localparam int IDX_W     = $clog2(MAX_NOTES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [SONG_W-1:0]       song_sel,
  input  logic [IDX_W:0]          song_len,
  input  logic                    abort,
  input  logic                    pause,
  output logic [SONG_W+IDX_W-1:0] mem_addr,
  output logic                    mem_rd,
  input  logic [TILE_W+DUR_W-1:0] mem_data,
  output logic                    tx_valid,
  output logic [7:0]              tx_data,
  input  logic                    tx_ready,
  output logic                    busy,
  output logic                    done,
  output logic [IDX_W:0]          note_idx,
  output logic                    dur_err
);

`ifdef NOTE_STREAM_FRAMING_EN
  localparam state_t ST_NOTE_END = ST_SEND2;
  localparam state_t ST_SONG_END = ST_TERM;
`else
  localparam state_t ST_NOTE_END = ST_SEND1;
  localparam state_t ST_SONG_END = ST_DONE;
`endif

  state_t            state_d,    state_q;
  logic [SONG_W-1:0] song_d,     song_q;
  logic [IDX_W:0]    note_idx_d, note_idx_q;
  logic              tx_valid_d, tx_valid_q;
  logic              dur_err_d,  dur_err_q;

  logic [IDX_W:0] len_eff;
  logic           last_note;
  logic           xfer;
  logic           hold_valid;
  logic [7:0]     fmt_buf0;
  logic [7:0]     fmt_buf1;
  logic           fmt_err;
  logic [7:0]     byte_sel;

  note_fmt #(
    .TILE_W (TILE_W),
    .DUR_W  (DUR_W)
  ) u_fmt (
    .clk  (clk),
    .rst  (rst),
    .load (state_q == ST_WAIT),
    .note (mem_data),
    .buf0 (fmt_buf0),
    .buf1 (fmt_buf1),
    .err  (fmt_err)
  );

  assign len_eff   = (song_len > (IDX_W+1)'(MAX_NOTES)) ? (IDX_W+1)'(MAX_NOTES) : song_len;
  assign last_note = (note_idx_q == len_eff);
  assign xfer      = tx_valid_q && tx_ready;
  // pause only gates a byte that has not been offered yet
  assign hold_valid = tx_valid_q || !pause;

  always_comb begin
    state_d    = state_q;
    song_d     = song_q;
    note_idx_d = note_idx_q;
    tx_valid_d = tx_valid_q;
    dur_err_d  = dur_err_q;

    // a byte accepted in the abort cycle still counts as sent
    if (xfer && state_q == ST_SEND1 && fmt_err) dur_err_d = 1'b1;
    if (xfer && state_q == ST_NOTE_END)         note_idx_d = note_idx_q + 1'b1;

    if (abort) begin
      state_d    = ST_IDLE;
      tx_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d    = ST_CHECK;
            song_d     = song_sel;
            note_idx_d = '0;
            dur_err_d  = 1'b0;
          end
        end
        ST_CHECK: begin
          state_d = last_note ? ST_SONG_END : ST_WAIT;
`ifdef NOTE_STREAM_FRAMING_EN
          if (last_note) tx_valid_d = !pause;
`endif
        end
        ST_WAIT: begin
          state_d    = ST_SEND0;
          tx_valid_d = !pause;
        end
        ST_SEND0: begin
          if (xfer) state_d = ST_SEND1;
          tx_valid_d = xfer ? !pause : hold_valid;
        end
        ST_SEND1: begin
`ifdef NOTE_STREAM_FRAMING_EN
          if (xfer) state_d = ST_SEND2;
          tx_valid_d = xfer ? !pause : hold_valid;
`else
          if (xfer) state_d = ST_CHECK;
          tx_valid_d = xfer ? 1'b0 : hold_valid;
`endif
        end
`ifdef NOTE_STREAM_FRAMING_EN
        ST_SEND2: begin
          if (xfer) state_d = ST_CHECK;
          tx_valid_d = xfer ? 1'b0 : hold_valid;
        end
        ST_TERM: begin
          if (xfer) state_d = ST_DONE;
          tx_valid_d = xfer ? 1'b0 : hold_valid;
        end
`endif
        ST_DONE: state_d = ST_IDLE;
        default: begin
          state_d    = ST_IDLE;
          tx_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      song_q     <= '0;
      note_idx_q <= '0;
      tx_valid_q <= 1'b0;
      dur_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      song_q     <= song_d;
      note_idx_q <= note_idx_d;
      tx_valid_q <= tx_valid_d;
      dur_err_q  <= dur_err_d;
    end
  end

  always_comb begin
    case (state_q)
      ST_SEND0: byte_sel = fmt_buf0;
      ST_SEND1: byte_sel = fmt_buf1;
`ifdef NOTE_STREAM_FRAMING_EN
      ST_SEND2: byte_sel = ASCII_NL;
      ST_TERM:  byte_sel = ASCII_TERM;
`endif
      default:  byte_sel = 8'h00;
    endcase
    tx_data  = tx_valid_q ? byte_sel : 8'h00;
    mem_rd   = (state_q == ST_CHECK) && !last_note && !abort;
    mem_addr = mem_rd ? {song_q, note_idx_q[IDX_W-1:0]} : '0;
  end

  assign tx_valid = tx_valid_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign note_idx = note_idx_q;
  assign dur_err  = dur_err_q;

endmodule
`default_nettype wire

// File: tb/tb_note_stream_tx.sv
`default_nettype none
// ============================================================================
// tb_note_stream_tx : table-driven bench for note_stream_tx plus directed
// abort / pause / asynchronous-reset sequences.
// Revision: 1.0
// ============================================================================
module tb_note_stream_tx;

`ifdef NOTE_STREAM_FRAMING_EN
  localparam bit FRAMING = 1'b1;
`else
  localparam bit FRAMING = 1'b0;
`endif
  localparam int BPN    = FRAMING ? 3 : 2;
  localparam int GAP    = FRAMING ? 1 : 2;
  localparam int BUDGET = 2000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [1:0] song_sel = '0;
  logic [6:0] song_len = '0;
  logic       abort = 1'b0;
  logic       pause = 1'b0;
  logic [7:0] mem_addr;
  logic       mem_rd;
  logic [6:0] mem_data;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready = 1'b0;
  logic       busy;
  logic       done;
  logic [6:0] note_idx;
  logic       dur_err;

  logic [6:0] mem [0:255];
  int n_cmp = 0;
  int n_fail = 0;

  note_stream_tx dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .song_sel (song_sel),
    .song_len (song_len),
    .abort    (abort),
    .pause    (pause),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_data (mem_data),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .busy     (busy),
    .done     (done),
    .note_idx (note_idx),
    .dur_err  (dur_err)
  );

  always #5 clk = ~clk;

  // synchronous note memory: data one cycle after the read strobe
  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  typedef struct {
    int    song;
    int    len;
    int    mode;
    string exp;
    bit    err;
    int    notes;
    int    dcyc;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_str(input string name, input string act, input string exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
    end
  endtask

  function automatic string frame(input string s);
    string r = "";
    for (int i = 0; i + 1 < s.len(); i += 2) r = $sformatf("%s%s\n", r, s.substr(i, i + 1));
    return {r, "Z"};
  endfunction

  function automatic logic rdy(input int mode, input int cyc);
    case (mode)
      1:       return (cyc % 4) == 0;
      2:       return (cyc % 2) == 1;
      default: return 1'b1;
    endcase
  endfunction

  task automatic run_stream(input int song, input int len, input int mode,
                            output string got, output int first_v, output int done_cyc,
                            output int n_done, output int last_x, output int busy_cnt,
                            output int unstable, output int err_c1, output int err_done,
                            output int idx_done);
    logic       pstall = 1'b0;
    logic [7:0] pdata = 8'h00;
    got = ""; first_v = -1; done_cyc = -1; n_done = 0; last_x = -1; busy_cnt = 0;
    unstable = 0; err_c1 = -1; err_done = -1; idx_done = -1;
    @(negedge clk);
    song_sel = song[1:0]; song_len = len[6:0]; start = 1'b1; tx_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc < BUDGET; cyc++) begin
      tx_ready = rdy(mode, cyc);
      #1;
      if (busy) busy_cnt++;
      if (cyc == 1) err_c1 = int'(dur_err);
      if (pstall && !(tx_valid && tx_data == pdata)) unstable++;
      pstall = tx_valid && !tx_ready;
      pdata  = tx_data;
      if (tx_valid && first_v < 0) first_v = cyc;
      if (tx_valid && tx_ready) begin
        got = $sformatf("%s%c", got, tx_data);
        last_x = cyc;
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          err_done = int'(dur_err);
          idx_done = int'(note_idx);
        end
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
      @(negedge clk);
    end
    tx_ready = 1'b0;
  endtask

  initial begin
    vec_t  vt[7];
    string got, s64;
    int    fv, dc, nd, lx, bc, us, e1, ed, ix;
    int    nx, prem, vp, seen, dseen, dcy;

    for (int i = 0; i < 256; i++) mem[i] = {4'd0, 3'd1};
    mem[64 + 0] = {4'd0, 3'd2};
    mem[64 + 1] = {4'd8, 3'd1};
    mem[64 + 2] = {4'd9, 3'd7};
    mem[128 + 0] = {4'd5, 3'd0};
    mem[128 + 1] = {4'd15, 3'd3};
    mem[0] = {4'd1, 3'd4};
    mem[1] = {4'd3, 3'd2};
    for (int i = 0; i < 64; i++) mem[192 + i] = {4'd2, 3'd5};
    s64 = "";
    for (int i = 0; i < 64; i++) s64 = {s64, "c5"};

    //          song len mode  bytes     err notes done-cycle
    vt[0] = '{1,   3,  0,   "a2i1j7", 0,  3,    14};
    vt[1] = '{1,   3,  1,   "a2i1j7", 0,  3,    0};
    vt[2] = '{2,   2,  0,   "fXp3",   1,  2,    0};
    vt[3] = '{1,   0,  0,   "",       0,  0,    2};
    vt[4] = '{0,   2,  2,   "b4d2",   0,  2,    0};
    vt[5] = '{3,   70, 0,   s64,      0,  64,   0};
    vt[6] = '{1,   1,  0,   "a2",     0,  1,    0};

    // reset state
    #12;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_data_addr_idx_err", {tx_data, mem_addr, note_idx, dur_err}, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      string exp;
      exp = FRAMING ? frame(vt[i].exp) : vt[i].exp;
      run_stream(vt[i].song, vt[i].len, vt[i].mode, got, fv, dc, nd, lx, bc, us, e1, ed, ix);
      check_str($sformatf("v%0d_bytes", i), got, exp);
      if (exp.len() == 0) check($sformatf("v%0d_first_valid", i), fv, -1);
      else check($sformatf("v%0d_first_valid", i), fv, (FRAMING && vt[i].len == 0) ? 2 : 3);
      check($sformatf("v%0d_done_pulses", i), nd, 1);
      if (lx >= 0) check($sformatf("v%0d_done_gap", i), dc - lx, GAP);
      if (!FRAMING && vt[i].dcyc > 0) check($sformatf("v%0d_done_cycle", i), dc, vt[i].dcyc);
      check($sformatf("v%0d_err_cleared", i), e1, 0);
      check($sformatf("v%0d_err_at_done", i), ed, int'(vt[i].err));
      check($sformatf("v%0d_idx_at_done", i), ix, vt[i].notes);
      check($sformatf("v%0d_stable", i), us, 0);
      check($sformatf("v%0d_busy_cycles", i), bc, dc);
    end

    // abort while SEND1 of the second note is stalled
    @(negedge clk);
    song_sel = 2'd1; song_len = 7'd3; start = 1'b1; tx_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; nx = 0; seen = 0;
    for (int c = 0; c < 100 && seen == 0; c++) begin
      tx_ready = (nx < BPN + 1);
      #1;
      if (tx_valid && tx_ready) nx++;
      else if (nx == BPN + 1 && tx_valid) seen = 1;
      if (seen == 0) @(negedge clk);
    end
    check("abort_reached_send1", seen, 1);
    check("abort_stalled_byte", tx_data, 8'h31);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    check("abort_tx_valid", tx_valid, 0);
    check("abort_busy", busy, 0);
    dseen = 0;
    for (int c = 0; c < 5; c++) begin
      if (done || tx_valid) dseen++;
      @(negedge clk);
      #1;
    end
    check("abort_no_done", dseen, 0);
    run_stream(1, 3, 0, got, fv, dc, nd, lx, bc, us, e1, ed, ix);
    check_str("abort_replay", got, FRAMING ? frame("a2i1j7") : "a2i1j7");

    // pause held for 5 cycles between notes
    @(negedge clk);
    song_sel = 2'd1; song_len = 7'd3; start = 1'b1; tx_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; got = ""; nx = 0; prem = 0; vp = 0; dseen = 0; dcy = -1;
    for (int c = 1; c < 300 && dseen == 0; c++) begin
      pause = (prem > 0);
      if (prem > 0) prem--;
      #1;
      if (pause && tx_valid) vp++;
      if (tx_valid && tx_ready) begin
        got = $sformatf("%s%c", got, tx_data);
        nx++;
        if (nx == BPN) prem = 5;
      end
      if (done) begin
        dseen = 1;
        dcy = c;
      end
      @(negedge clk);
    end
    pause = 1'b0;
    check("pause_no_valid", vp, 0);
    check_str("pause_bytes", got, FRAMING ? frame("a2i1j7") : "a2i1j7");
    check("pause_done_seen", dseen, 1);
    if (!FRAMING) check("pause_done_cycle", dcy, 18);

    // asynchronous reset mid-stream
    @(negedge clk);
    song_sel = 2'd1; song_len = 7'd3; start = 1'b1; tx_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      #1;
      if (tx_valid) seen = 1;
      else @(negedge clk);
    end
    check("areset_valid_reached", seen, 1);
    #2 rst = 1'b0;
    #1;
    check("areset_tx_valid", tx_valid, 0);
    check("areset_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    run_stream(1, 1, 0, got, fv, dc, nd, lx, bc, us, e1, ed, ix);
    check_str("areset_recover", got, FRAMING ? frame("a2") : "a2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
